bitmap_fetch: RTL and testbench
===============================

Name: bitmap_fetch

Overview:
- Downstream consumer of the dual-port display memory, on the memory read port (rd_en/rd_address/rd_data).
- Walks display memory in raster order: one read per word, each word holding PIX_PER_WORD packed colour indices.
- Serialises each word into one pixel index per clock for the palette/output stage.
- Hides the memory's 1-cycle registered read latency with a one-word prefetch buffer.
- Supports vertical line repeat for low-resolution modes.

Parameters:
- ADDR_W, 10, display memory address width; matches memory ADDR_W.
- DATA_W, 16, memory word width; matches memory DATA_W.
- PIX_W, 4, bits per pixel index. DATA_W must be a multiple of PIX_W, and PIX_PER_WORD = DATA_W/PIX_W must be >= 2.
- WORDS_PER_LINE, 40, words fetched per displayed line.
- V_REPEAT, 1, times each memory line is displayed (>=1).

Ports:
- clk  in  1  pixel clock; also the memory rd_clk
- reset_ni  in  1  synchronous active-low reset
- frame_start_i  in  1  one-cycle pulse, start of frame
- line_start_i  in  1  one-cycle pulse; at least 3 clocks before the line's first active_i
- active_i  in  1  visible-pixel window for the current line
- base_addr_i  in  ADDR_W  frame base word address; sampled on frame_start_i
- mem_rd_en_o  out  1  to memory rd_en_i
- mem_rd_addr_o  out  ADDR_W  to memory rd_address_i
- mem_rd_data_i  in  DATA_W  from memory rd_data_o; valid the cycle after mem_rd_en_o
- pixel_o  out  PIX_W  pixel colour index
- pixel_valid_o  out  1  pixel_o corresponds to an active_i cycle
- underflow_o  out  1  one-cycle pulse: active pixel requested with no data available

Behaviour:
- Single clock domain. Reset (reset_ni=0 at posedge):
  - all outputs 0
  - state IDLE
  - line_addr=0, rep_cnt=0, word counters 0
  - buffers marked empty
  - Reset mid-line aborts fetch immediately; no further reads are issued.
- frame_start_i: line_addr<=base_addr_i, rep_cnt<=0, state<=IDLE.
- frame_start_i and line_start_i in the same cycle: frame action first, then line start fetches from base_addr_i.
- line_start_i in any state restarts the line:
  - fetch_addr<=line_addr, words_issued<=0, words_used<=0, buffers emptied, state<=PRIME.
- PRIME:
  - assert mem_rd_en_o, mem_rd_addr_o=fetch_addr; fetch_addr++ (wraps mod 2^ADDR_W); words_issued++.
  - Next state LOAD.
- LOAD:
  - mem_rd_data_i is loaded into the shift register; pix_cnt=0.
  - If words_issued<WORDS_PER_LINE, issue the next read; its data lands in next_word the following cycle and next_valid is set.
  - Next state RUN.
- RUN, with active_i=1 each cycle:
  - pixel_o<=shift[DATA_W-1 -: PIX_W] (MSB pixel first), pixel_valid_o<=1, shift left by PIX_W, pix_cnt++.
  - When pix_cnt==PIX_PER_WORD-1, the word is consumed and words_used++.
    - If next_valid: shift<=next_word, next_valid<=0, and issue the next read if words_issued<WORDS_PER_LINE.
    - Else if words_used reaches WORDS_PER_LINE: state DONE.
- RUN, with active_i=0: shift, pix_cnt and outputs hold; pixel_valid_o<=0; no reads issued.
- Latency: pixel_o/pixel_valid_o are registered, one clock after the active_i cycle that consumes them.
- active_i=1 in IDLE, PRIME, LOAD or DONE:
  - pixel_o<=0, pixel_valid_o<=1.
  - underflow_o pulses in IDLE/PRIME/LOAD; DONE is a normal end of line and does not pulse.
- Entering DONE:
  - rep_cnt++.
  - If rep_cnt reaches V_REPEAT: rep_cnt<=0, line_addr<=line_addr+WORDS_PER_LINE (mod 2^ADDR_W).
  - Otherwise line_addr is unchanged, so the same line is re-read.
- mem_rd_en_o is high only in cycles that issue a read; mem_rd_addr_o holds its last value otherwise.
- Exactly WORDS_PER_LINE reads per line; never reads past the line end.

Test Plan:
- Memory is preloaded with test pattern mem[i]={~i[7:4],i[7:4],i[7:0]}.
- Reset: reset_ni=0 for 2 clocks while pulsing line_start_i -> all outputs 0, mem_rd_en_o never asserted.
- Basic line:
  - Stimulus: base_addr_i=0x012, frame_start, line_start, 3 idle clocks, then active_i for 160 cycles.
  - Required reads: addresses 0x012..0x039, one each.
  - Required first pixels: E,1,1,2 (word 0xE112), then E,1,1,3.
  - No underflow_o.
- Line advance: V_REPEAT=2, three lines -> lines 1 and 2 start reading at 0x012, line 3 at 0x03A.
- Wrap: base_addr_i=0x3F0, WORDS_PER_LINE=40 -> read addresses wrap 0x3FF to 0x000 and continue to 0x017.
- Stalls:
  - Stimulus: active_i toggled 1,0,1,0 across word boundaries.
  - Required: pixel sequence identical to the continuous case; pixel_valid_o low in the gap cycles; reads never exceed one word ahead.
- Late start: active_i asserted 1 cycle after line_start_i -> underflow_o pulses, pixel_o=0 with pixel_valid_o=1 until the first word loads.
- Mid-line restart: line_start_i at pixel 50 -> fetch restarts at line_addr, buffers flushed, next pixels come from the line's word 0.

Source files
------------

// File: rtl/bitmap_fetch.sv
// bitmap_fetch: raster-order display memory reader that serialises packed words into pixel indices.
//   clk            pixel clock, also the memory read clock
//   reset_ni       synchronous active-low reset
//   frame_start_i  start-of-frame pulse; samples base_addr_i
//   line_start_i   start-of-line pulse; restarts the line fetch
//   active_i       visible-pixel window
//   base_addr_i    frame base word address
//   mem_rd_en_o    memory read enable
//   mem_rd_addr_o  memory read address
//   mem_rd_data_i  memory read data, valid the cycle after mem_rd_en_o
//   pixel_o        pixel colour index (registered)
//   pixel_valid_o  pixel_o belongs to an active_i cycle
//   underflow_o    active pixel requested before any data was available
module bitmap_fetch #(
   parameter int ADDR_W         = 10,
   parameter int DATA_W         = 16,
   parameter int PIX_W          = 4,
   parameter int WORDS_PER_LINE = 40,
   parameter int V_REPEAT       = 1
) (
   input  logic              clk,
   input  logic              reset_ni,
   input  logic              frame_start_i,
   input  logic              line_start_i,
   input  logic              active_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_rd_addr_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic [PIX_W-1:0]  pixel_o,
   output logic              pixel_valid_o,
   output logic              underflow_o
);
   localparam int PPW = DATA_W / PIX_W;
   localparam int PCW = $clog2(PPW);
   localparam int WW  = $clog2(WORDS_PER_LINE + 1);
   localparam int RW  = $clog2(V_REPEAT + 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRIME = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] line_addr_q, line_addr_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [RW-1:0]     rep_cnt_q, rep_cnt_d;
   logic [WW-1:0]     words_issued_q, words_issued_d;
   logic [WW-1:0]     words_used_q, words_used_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] next_word_q, next_word_d;
   logic              next_valid_q, next_valid_d;
   logic              pend_q, pend_d;
   logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
   logic [PIX_W-1:0]  pixel_q, pixel_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic              underflow_q, underflow_d;
   logic              last_pix, more_words, consume, issue, line_done, rep_hit;

   assign last_pix   = pix_cnt_q == PCW'(PPW - 1);
   assign more_words = words_issued_q < WW'(WORDS_PER_LINE);
   assign consume    = (state_q == S_RUN) && active_i && last_pix;
   assign line_done  = words_used_q + WW'(1) == WW'(WORDS_PER_LINE);
   assign rep_hit    = rep_cnt_q + RW'(1) == RW'(V_REPEAT);
   // A pulse on frame/line start flushes the pipeline, so no read may be issued
   // that cycle; reset gates the enable combinationally to abort immediately.
   assign issue = reset_ni && !line_start_i && !frame_start_i &&
                  ((state_q == S_PRIME) || ((state_q == S_LOAD) && more_words) ||
                   (consume && next_valid_q && more_words));

   assign mem_rd_en_o   = issue;
   assign mem_rd_addr_o = issue ? fetch_addr_q : rd_addr_q;
   assign pixel_o       = pixel_q;
   assign pixel_valid_o = pixel_valid_q;
   assign underflow_o   = underflow_q;

   always_comb begin
      state_d        = state_q;
      line_addr_d    = line_addr_q;
      fetch_addr_d   = fetch_addr_q;
      rep_cnt_d      = rep_cnt_q;
      words_issued_d = words_issued_q;
      words_used_d   = words_used_q;
      shift_d        = shift_q;
      pix_cnt_d      = pix_cnt_q;
      pixel_valid_d  = active_i;
      pixel_d        = (active_i && state_q != S_RUN) ? '0 : pixel_q;
      underflow_d    = active_i && (state_q == S_IDLE || state_q == S_PRIME || state_q == S_LOAD);
      // Prefetched data lands one cycle after its read was issued.
      next_word_d    = pend_q ? mem_rd_data_i : next_word_q;
      next_valid_d   = next_valid_q || pend_q;
      pend_d         = 1'b0;
      if (issue) begin
         fetch_addr_d   = fetch_addr_q + ADDR_W'(1);
         words_issued_d = words_issued_q + WW'(1);
         pend_d         = state_q != S_PRIME;
      end
      case (state_q)
         S_PRIME: state_d = S_LOAD;
         S_LOAD: begin
            shift_d   = mem_rd_data_i;
            pix_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (active_i) begin
               pixel_d   = shift_q[DATA_W-1 -: PIX_W];
               shift_d   = shift_q << PIX_W;
               pix_cnt_d = last_pix ? '0 : pix_cnt_q + PCW'(1);
               if (last_pix) begin
                  words_used_d = words_used_q + WW'(1);
                  if (next_valid_q) begin
                     shift_d      = next_word_q;
                     next_valid_d = 1'b0;
                  end else if (line_done) begin
                     state_d     = S_DONE;
                     rep_cnt_d   = rep_hit ? '0 : rep_cnt_q + RW'(1);
                     line_addr_d = rep_hit ? line_addr_q + ADDR_W'(WORDS_PER_LINE) : line_addr_q;
                  end
               end
            end
         end
         default: ;
      endcase
      if (frame_start_i) begin
         line_addr_d = base_addr_i;
         rep_cnt_d   = '0;
         state_d     = S_IDLE;
      end
      if (line_start_i) begin
         fetch_addr_d   = frame_start_i ? base_addr_i : line_addr_q;
         words_issued_d = '0;
         words_used_d   = '0;
         next_valid_d   = 1'b0;
         pend_d         = 1'b0;
         state_d        = S_PRIME;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         state_q        <= S_IDLE;
         line_addr_q    <= '0;
         fetch_addr_q   <= '0;
         rd_addr_q      <= '0;
         rep_cnt_q      <= '0;
         words_issued_q <= '0;
         words_used_q   <= '0;
         shift_q        <= '0;
         next_word_q    <= '0;
         next_valid_q   <= 1'b0;
         pend_q         <= 1'b0;
         pix_cnt_q      <= '0;
         pixel_q        <= '0;
         pixel_valid_q  <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         line_addr_q    <= line_addr_d;
         fetch_addr_q   <= fetch_addr_d;
         rd_addr_q      <= mem_rd_addr_o;
         rep_cnt_q      <= rep_cnt_d;
         words_issued_q <= words_issued_d;
         words_used_q   <= words_used_d;
         shift_q        <= shift_d;
         next_word_q    <= next_word_d;
         next_valid_q   <= next_valid_d;
         pend_q         <= pend_d;
         pix_cnt_q      <= pix_cnt_d;
         pixel_q        <= pixel_d;
         pixel_valid_q  <= pixel_valid_d;
         underflow_q    <= underflow_d;
      end
   end
endmodule

// File: tb/tb_bitmap_fetch.sv
// tb_bitmap_fetch: self-checking bench for bitmap_fetch with a registered-read memory model.
//   Drives frame/line/active stimulus from a vector table plus hand sequences;
//   expected pixels and read addresses are queued and popped by a monitor.
module tb_bitmap_fetch;
   localparam int AW = 10, DW = 16, PW = 4, WPL = 40, VR = 2, NPX = WPL * 4;

   logic          clk = 1'b0;
   logic          reset_ni = 1'b0;
   logic          frame_start_i = 1'b0;
   logic          line_start_i = 1'b0;
   logic          active_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic          mem_rd_en_o;
   logic [AW-1:0] mem_rd_addr_o;
   logic [DW-1:0] mem_rd_data_i = '0;
   logic [PW-1:0] pixel_o;
   logic          pixel_valid_o;
   logic          underflow_o;

   always #5 clk = ~clk;

   bitmap_fetch #(.ADDR_W(AW), .DATA_W(DW), .PIX_W(PW), .WORDS_PER_LINE(WPL), .V_REPEAT(VR)) dut (
      .clk(clk), .reset_ni(reset_ni), .frame_start_i(frame_start_i), .line_start_i(line_start_i),
      .active_i(active_i), .base_addr_i(base_addr_i), .mem_rd_en_o(mem_rd_en_o),
      .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i), .pixel_o(pixel_o),
      .pixel_valid_o(pixel_valid_o), .underflow_o(underflow_o)
   );

   function automatic logic [15:0] pat(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {~b[7:4], b[7:4], b};
   endfunction

   function automatic logic [3:0] exp_px(input logic [AW-1:0] a, input int k);
      logic [AW-1:0] wa;
      logic [15:0]   w;
      wa = a + AW'(k / 4);
      w  = pat(int'(wa));
      return w[15 - 4 * (k % 4) -: 4];
   endfunction

   logic [DW-1:0] mem [1024];
   initial for (int i = 0; i < 1024; i++) mem[i] = pat(i);
   always @(posedge clk) if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];

   typedef struct packed {logic [3:0] px; logic uf;} ent_t;
   ent_t          px_q[$];
   logic [AW-1:0] addr_q[$];
   int compared = 0, mismatched = 0;
   int rd_n = 0, px_n = 0;
   logic prev_act = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ent_t e;
      chk("pixel_valid", int'(pixel_valid_o), int'(prev_act));
      if (pixel_valid_o) begin
         if (px_q.size() == 0) chk("unexpected_pixel", 1, 0);
         else begin
            e = px_q.pop_front();
            chk("pixel", int'(pixel_o), int'(e.px));
            chk("underflow", int'(underflow_o), int'(e.uf));
            px_n++;
         end
      end else chk("underflow_idle", int'(underflow_o), 0);
      if (mem_rd_en_o) begin
         rd_n++;
         if (addr_q.size() == 0) chk("extra_read", int'(mem_rd_addr_o), -1);
         else chk("rd_addr", int'(mem_rd_addr_o), int'(addr_q.pop_front()));
         chk("read_ahead", int'(rd_n <= px_n / 4 + 3), 1);
      end
      prev_act = reset_ni ? active_i : 1'b0;
      if (line_start_i) begin
         rd_n = 0;
         px_n = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic push_addrs(input logic [AW-1:0] a);
      for (int i = 0; i < WPL; i++) addr_q.push_back(a + AW'(i));
   endtask

   task automatic start_line(input logic fr, input logic [AW-1:0] base, input logic [AW-1:0] exp_addr);
      if (fr) begin
         frame_start_i = 1'b1;
         base_addr_i   = base;
         step();
         frame_start_i = 1'b0;
      end
      line_start_i = 1'b1;
      push_addrs(exp_addr);
      step();
      line_start_i = 1'b0;
   endtask

   task automatic run_px(input logic [AW-1:0] a, input int from, input int n, input int gap);
      for (int k = from; k < from + n; k++) begin
         active_i = 1'b1;
         px_q.push_back({exp_px(a, k), 1'b0});
         step();
         if (gap != 0) begin
            active_i = 1'b0;
            step();
         end
      end
      active_i = 1'b0;
   endtask

   task automatic end_line(input string name);
      idle(4);
      chk({name, "_reads_left"}, addr_q.size(), 0);
      chk({name, "_pixels_left"}, px_q.size(), 0);
      addr_q.delete();
      px_q.delete();
   endtask

   typedef struct {
      logic          fr;
      logic [AW-1:0] base;
      logic [AW-1:0] exp_addr;
      int            gap;
      int            extra;
   } vec_t;
   vec_t tv[7];

   initial begin
      tv[0] = '{1'b1, 10'h012, 10'h012, 0, 1};
      tv[1] = '{1'b0, 10'h000, 10'h012, 0, 0};
      tv[2] = '{1'b0, 10'h000, 10'h03A, 1, 0};
      tv[3] = '{1'b0, 10'h000, 10'h03A, 0, 2};
      tv[4] = '{1'b1, 10'h3F0, 10'h3F0, 0, 0};
      tv[5] = '{1'b0, 10'h000, 10'h3F0, 1, 1};
      tv[6] = '{1'b0, 10'h000, 10'h018, 0, 0};

      // Reset held while line_start pulses: nothing may be issued or output.
      line_start_i = 1'b1;
      step();
      line_start_i = 1'b0;
      step();
      chk("reset_pixel", int'(pixel_o), 0);
      chk("reset_valid", int'(pixel_valid_o), 0);
      chk("reset_underflow", int'(underflow_o), 0);
      chk("reset_rd_en", int'(mem_rd_en_o), 0);
      chk("reset_rd_addr", int'(mem_rd_addr_o), 0);
      reset_ni = 1'b1;
      idle(3);
      chk("idle_rd_en", int'(mem_rd_en_o), 0);

      for (int v = 0; v < 7; v++) begin
         start_line(tv[v].fr, tv[v].base, tv[v].exp_addr);
         idle(3);
         run_px(tv[v].exp_addr, 0, NPX, tv[v].gap);
         for (int x = 0; x < tv[v].extra; x++) begin
            active_i = 1'b1;
            px_q.push_back({4'h0, 1'b0});
            step();
         end
         active_i = 1'b0;
         end_line($sformatf("line%0d", v));
      end

      // Frame and line start together, active one cycle later: two underflow pixels.
      frame_start_i = 1'b1;
      line_start_i  = 1'b1;
      base_addr_i   = 10'h100;
      push_addrs(10'h100);
      step();
      frame_start_i = 1'b0;
      line_start_i  = 1'b0;
      for (int x = 0; x < 2; x++) begin
         active_i = 1'b1;
         px_q.push_back({4'h0, 1'b1});
         step();
      end
      run_px(10'h100, 0, NPX, 0);
      end_line("late_start");

      // Restart at pixel 50: 14 words fetched so far, then the line starts over.
      start_line(1'b1, 10'h200, 10'h200);
      idle(3);
      run_px(10'h200, 0, 50, 0);
      chk("restart_reads_left", addr_q.size(), WPL - 14);
      addr_q.delete();
      line_start_i = 1'b1;
      push_addrs(10'h200);
      step();
      line_start_i = 1'b0;
      idle(3);
      run_px(10'h200, 0, NPX, 0);
      end_line("restart");

      // Reset after 20 pixels: 7 reads made, none afterwards.
      start_line(1'b1, 10'h080, 10'h080);
      idle(3);
      run_px(10'h080, 0, 20, 0);
      reset_ni = 1'b0;
      idle(2);
      reset_ni = 1'b1;
      idle(4);
      chk("reset_abort_reads_left", addr_q.size(), WPL - 7);
      chk("reset_abort_pixels_left", px_q.size(), 0);
      chk("reset_abort_valid", int'(pixel_valid_o), 0);
      addr_q.delete();
      px_q.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
